// File: rtl/fifo_uart_pkg.sv
// Shared types for the FIFO-fed UART transmitter; FIFO_UART_TX_PARITY_EN adds the PARITY state.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPTURE,
    START,
    DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Bit-period counter: bit_tick on the last cycle of each serial bit, near_tick one cycle earlier.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick,
  output logic near_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] NEAR = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear || cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick  = !clear && (cnt_q == LAST);
  assign near_tick = !clear && (cnt_q == NEAR);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous FIFO and sends them as 8N1 UART frames on txd.
// Defining FIFO_UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rs,
  output logic                  fifo_re,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  pop_q, pop_d;
  logic                  done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic baud_clr, bit_tick, near_tick;

  // Counter held at zero until the start bit begins, so every bit is a full period.
  assign baud_clr = (state_q == IDLE) || (state_q == POP) || (state_q == CAPTURE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk       (clk),
    .reset     (reset),
    .clear     (baud_clr),
    .bit_tick  (bit_tick),
    .near_tick (near_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
    pop_d     = 1'b0;
    done_d    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = POP;
          pop_d   = 1'b1;
        end
      end
      POP: state_d = CAPTURE;
      CAPTURE: begin
        shift_d   = fifo_data;
        bit_cnt_d = '0;
        txd_d     = START_BIT;
        state_d   = START;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d  = ^fifo_data;
`endif
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d   = PARITY;
            txd_d     = parity_q;
`else
            state_d   = STOP;
            txd_d     = TXD_IDLE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          txd_d   = TXD_IDLE;
        end
      end
`endif
      STOP: begin
        done_d = near_tick;
        if (bit_tick) begin
          if (enable && !fifo_empty) begin
            state_d = POP;
            pop_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = TXD_IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= TXD_IDLE;
      busy_q    <= 1'b0;
      pop_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      pop_q     <= pop_d;
      done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_rs    = pop_q;
  assign fifo_re    = pop_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural registered FIFO on the read side.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rs, fifo_re, txd, busy, frame_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int bad_pop = 0;
  int rs_re_diff = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Registered-read FIFO model: data appears one clk after the pop edge.
  always @(posedge clk) begin
    if (fifo_rs !== fifo_re) rs_re_diff <= rs_re_diff + 1;
    if (fifo_rs && fifo_re) begin
      pop_cnt <= pop_cnt + 1;
      if (wr_ptr == rd_ptr) begin
        bad_pop <= bad_pop + 1;
      end else begin
        fifo_data <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rs    (fifo_rs),
    .fifo_re    (fifo_re),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef FIFO_UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Entered on the first cycle of the start bit; returns on the cycle after the stop bit.
  task automatic check_frame(input logic [7:0] b, input int drop_at);
    for (int c = 0; c < NBITS * CPB; c++) begin
      chk("txd_bit", txd, frame_bit(b, c / CPB));
      chk("frame_done", frame_done, (c == NBITS * CPB - 1));
      if (c == drop_at) enable = 1'b0;
      step(1);
    end
  endtask

  // From the IDLE cycle with a freshly pushed byte: POP, CAPTURE, then the start bit.
  task automatic expect_pop_lead;
    step(1);
    chk("pop_rs", fifo_rs, 1'b1);
    chk("pop_re", fifo_re, 1'b1);
    chk("pop_busy", busy, 1'b1);
    chk("pop_txd", txd, 1'b1);
    step(1);
    chk("cap_rs", fifo_rs, 1'b0);
    chk("cap_txd", txd, 1'b1);
    step(1);
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rs", fifo_rs, 1'b0);
    chk("rst_re", fifo_re, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    reset = 1'b0;
    enable = 1'b1;
    step(2);

    // Single frame 0xA5
    push(8'hA5);
    expect_pop_lead();
    check_frame(8'hA5, -1);
    chk("a5_idle_busy", busy, 1'b0);
    chk("a5_idle_txd", txd, 1'b1);
    chk("a5_pops", pop_cnt, 1);

    // Back-to-back 0x01, 0x80 with a two-cycle gap
    push(8'h01);
    push(8'h80);
    expect_pop_lead();
    check_frame(8'h01, -1);
    chk("b2b_pop_rs", fifo_rs, 1'b1);
    chk("b2b_pop_txd", txd, 1'b1);
    chk("b2b_pop_busy", busy, 1'b1);
    step(1);
    chk("b2b_cap_rs", fifo_rs, 1'b0);
    chk("b2b_cap_txd", txd, 1'b1);
    step(1);
    check_frame(8'h80, -1);
    chk("b2b_busy", busy, 1'b0);
    chk("b2b_pops", pop_cnt, 3);

    // Empty FIFO with enable held
    for (int i = 0; i < 100; i++) begin
      chk("empty_outs", {fifo_rs, fifo_re, txd, busy}, 4'b0010);
      step(1);
    end

    // enable dropped during DATA of 0x3C with 0x55 queued
    push(8'h3C);
    push(8'h55);
    expect_pop_lead();
    check_frame(8'h3C, 12);
    chk("dis_busy", busy, 1'b0);
    for (int i = 0; i < 20; i++) begin
      chk("dis_no_pop", fifo_rs, 1'b0);
      step(1);
    end
    chk("dis_pops", pop_cnt, 4);
    enable = 1'b1;
    expect_pop_lead();
    check_frame(8'h55, -1);
    chk("dis_pops2", pop_cnt, 5);

    // Reset during data bit 3 of 0x96, then 0x4B sent in full
    push(8'h96);
    push(8'h4B);
    expect_pop_lead();
    step(4 * CPB + 2);
    reset = 1'b1;
    #1;
    chk("arst_txd", txd, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_rs", fifo_rs, 1'b0);
    step(2);
    reset = 1'b0;
    expect_pop_lead();
    check_frame(8'h4B, -1);
    chk("arst_idle_busy", busy, 1'b0);
    chk("arst_pops", pop_cnt, 7);

    // 0x07: odd payload, parity bit 1 when parity is built
    push(8'h07);
    expect_pop_lead();
    check_frame(8'h07, -1);
    chk("x07_busy", busy, 1'b0);
    chk("final_pops", pop_cnt, 8);
    chk("bad_pops", bad_pop, 0);
    chk("rs_re_match", rs_re_diff, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the team's synchronous FIFO.
- Pops one byte at a time over the FIFO's read-strobe/read-enable pair and serialises it as an 8N1 asynchronous UART frame on `txd`.
- Sits directly downstream of the FIFO, between FIFO `data_out`/`empty` and the board-level serial pin.
- Drains the FIFO continuously while `enable` is high and the FIFO is non-empty.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and the serial payload; bits are sent LSB first.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  allows new pops; sampled only in IDLE and on the last cycle of STOP.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_WIDTH  FIFO registered read data; valid one clk after the pop edge.
- fifo_rs  output  1  FIFO read strobe; single-cycle pulse per pop.
- fifo_re  output  1  FIFO read enable; identical timing to fifo_rs.
- txd  output  1  serial line, registered; idle level is 1.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  single-cycle pulse on the final clk of the stop bit.

Behaviour:
- Reset (async, immediate): txd=1, busy=0, fifo_rs=0, fifo_re=0, frame_done=0, state=IDLE, bit counter=0, baud counter=0. Reset mid-frame aborts the frame; the popped byte is lost and there is no retry.
- States: IDLE, POP, CAPTURE, START, DATA, STOP (plus PARITY when the optional feature is built).
- IDLE -> POP when enable=1 and fifo_empty=0. POP drives fifo_rs=fifo_re=1 for exactly one cycle.
- POP -> CAPTURE unconditionally.
- CAPTURE: shift_reg <= fifo_data, then -> START. fifo_empty is ignored from POP onward.
- START: txd=0 for CLKS_PER_BIT cycles.
- DATA: txd=shift_reg[0]; shift right on each bit tick; DATA_WIDTH bits, each lasting CLKS_PER_BIT cycles.
- STOP: txd=1 for CLKS_PER_BIT cycles; frame_done=1 on its last cycle.
  - On that last cycle, if enable=1 and fifo_empty=0 -> POP (back-to-back).
  - Otherwise -> IDLE.
- Latency: from the IDLE cycle that sees a non-empty FIFO, txd falls on the 3rd rising edge (POP, CAPTURE, START-entry).
- Inter-frame gap when back-to-back: txd stays 1 for 2 extra cycles (POP, CAPTURE).
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- Baud counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1. It is cleared on entry to START and wraps on every bit tick. The bit counter wraps at DATA_WIDTH-1.
- enable=0 mid-frame: the current frame completes normally; no further pop is issued.
- fifo_rs/fifo_re are never asserted outside POP. In particular, no pop is ever issued while fifo_empty=1.

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the payload) is inserted between DATA and STOP for CLKS_PER_BIT cycles. Frame is 8E1.
- Undefined: no PARITY state exists; DATA -> STOP directly. Frame is 8N1.

Decomposition:
- Package fifo_uart_pkg holds:
  - tx_state_t enum typedef for the states.
  - TXD_IDLE=1'b1 and START_BIT=1'b0 constants.
- One sub-module, uart_baud_tick: parameterised CLKS_PER_BIT counter with clear input, outputs a single-cycle bit_tick. fifo_uart_tx instantiates it once.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8):
- FIFO holds 0xA5, enable=1 -> one fifo_rs/fifo_re pulse, then txd = 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles. frame_done pulses at cycle 40 of the frame; busy then drops.
- FIFO holds 0x01,0x80, enable held -> two frames separated by exactly 2 extra high cycles. Payloads are 1,0,0,0,0,0,0,0 then 0,0,0,0,0,0,0,1. Exactly 2 pops total.
- fifo_empty=1, enable=1 for 100 cycles -> fifo_rs=fifo_re=0 throughout, txd=1, busy=0.
- Deassert enable during DATA of 0x3C with a second byte queued -> the 0x3C frame completes and the FSM returns to IDLE. No second pop occurs until enable rises again.
- Assert reset during bit 3 of a frame -> txd=1, busy=0 in the same cycle (async). After release with FIFO non-empty, a fresh pop occurs and a full frame is sent.
- FIFO_UART_TX_PARITY_EN defined: 0xA5 gives parity bit 0 and 0x07 gives parity bit 1. Frame length is 44 cycles.
